// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Byte-enabled data memory on the data-SRAM side of the CPU data interface.
// Loads return a full 32-bit word one clock after the access cycle. The MEM
// stage does the lane extraction and sign/zero extension. An optional number
// of read wait-states makes the block behave like slow memory: it raises
// stallreq toward the pipeline stall controller until the data is ready.
//
// Parameters:
//   ADDR_W       word-address width; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra read latency in cycles (0 = single-cycle read)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (array contents are kept)
//   data_sram_en     access request
//   data_sram_wen    byte write enables, wen[3] -> bits 31:24 ... wen[0] -> 7:0;
//                    all-zero means read
//   data_sram_addr   byte address; word index = addr[ADDR_W+1:2]
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered read data (full word)
//   stallreq         hold request while a slow read is pending
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) + 1 : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] LAST = 2'd2;

    logic [31:0]       mem_r [0:DEPTH-1];
    logic [31:0]       rdata_r;
    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [ADDR_W-1:0] idx_s;
    logic              read_s;
    logic              write_s;
    logic              wr_commit_s;
    logic              load_rdata_s;
    logic              stall_s;
    logic              unused_addr_s;

    assign idx_s   = data_sram_addr[ADDR_W+1:2];
    assign read_s  = data_sram_en & (data_sram_wen == 4'b0000);
    assign write_s = data_sram_en & (data_sram_wen != 4'b0000);

    // Byte-offset and upper address bits deliberately play no part in indexing,
    // which is what makes addresses wrap modulo the array size.
    assign unused_addr_s = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Next-state, counter and stall decode; stallreq uses only state, en and wen.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        stall_s      = 1'b0;
        load_rdata_s = 1'b0;
        wr_commit_s  = 1'b0;
        case (state_r)
            IDLE: begin
                wr_commit_s = write_s;
                if (read_s) begin
                    if (WAIT_CYCLES == 0) begin
                        load_rdata_s = 1'b1;
                    end else begin
                        stall_s    = 1'b1;
                        cnt_next_s = CNT_W'(WAIT_CYCLES - 1);
                        if (WAIT_CYCLES > 1) begin
                            state_next_s = WAIT;
                        end else begin
                            state_next_s = LAST;
                        end
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                // Bus is held stable by the pipeline; nothing on it is decoded here.
                stall_s    = 1'b1;
                cnt_next_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = LAST;
                end else begin
                    state_next_s = WAIT;
                end
            end
            LAST: begin
                // Complete the held read; the still-held request is not a new access.
                load_rdata_s = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, wait counter and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (load_rdata_s) begin
                rdata_r <= mem_r[idx_s];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Storage array: per-lane writes, never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem_r[idx_s][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_r;
    assign stallreq        = stall_s;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk;
    logic        rst;

    // Single-cycle instance (WAIT_CYCLES = 0)
    logic        en0;
    logic [3:0]  wen0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        stall0;

    // Slow instance (WAIT_CYCLES = 3)
    logic        en1;
    logic [3:0]  wen1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] rdata1;
    logic        stall1;

    int checks;
    int errors;

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en0),
        .data_sram_wen   (wen0),
        .data_sram_addr  (addr0),
        .data_sram_wdata (wdata0),
        .data_sram_rdata (rdata0),
        .stallreq        (stall0)
    );

    data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en1),
        .data_sram_wen   (wen1),
        .data_sram_addr  (addr1),
        .data_sram_wdata (wdata1),
        .data_sram_rdata (rdata1),
        .stallreq        (stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata; // value expected on rdata during this cycle
        logic        exp_stall;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle on the slow instance: drive after the falling edge, check before the rising edge.
    task automatic cyc1(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_stall,
                        input logic [31:0] exp_rdata, input string name);
        @(negedge clk);
        en1 = en; wen1 = wen; addr1 = addr; wdata1 = wdata;
        #1;
        check({name, "_stall"}, {31'd0, stall1}, {31'd0, exp_stall});
        check({name, "_rdata"}, rdata1, exp_rdata);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en0 = 1'b0; wen0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
        en1 = 1'b0; wen1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;

        //                en    wen    addr           wdata          exp_rdata      exp_stall
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 4'h4, 32'h0000_0020, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 4'h3, 32'h0000_0020, 32'h0000_BBCC, 32'h11AA_3344, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h11AA_3344, 1'b0};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 32'h11AA_BBCC, 1'b0};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0002, 32'h11AA_BBCC, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h0000_0003, 32'h11AA_BBCC, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h11AA_BBCC, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0002, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[15] = '{1'b1, 4'hF, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        vecs[16] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[17] = '{1'b1, 4'hF, 32'h0000_1000, 32'h0000_0077, 32'h0000_0003, 1'b0};
        vecs[18] = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003, 1'b0};
        vecs[19] = '{1'b1, 4'h0, 32'h0000_1003, 32'h0000_0000, 32'h0000_0077, 1'b0};
        vecs[20] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0077, 1'b0};
        // en=0 with wen set is idle and must not write word 1
        vecs[21] = '{1'b0, 4'hF, 32'h0000_0004, 32'hCAFE_F00D, 32'h0000_0077, 1'b0};
        vecs[22] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0077, 1'b0};
        vecs[23] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_stall0", {31'd0, stall0}, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_stall1", {31'd0, stall1}, 32'h0);

        // Single-cycle instance: table-driven
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            en0 = vecs[i].en; wen0 = vecs[i].wen; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
            #1;
            check($sformatf("w0_vec%0d_rdata", i), rdata0, vecs[i].exp_rdata);
            check($sformatf("w0_vec%0d_stall", i), {31'd0, stall0}, {31'd0, vecs[i].exp_stall});
        end
        @(negedge clk);
        en0 = 1'b0; wen0 = 4'h0;

        // Slow instance: preload, then a held read with three stall cycles
        cyc1(1'b1, 4'hF, 32'h40, 32'h5A5A_5A5A, 1'b0, 32'h0, "w3_write");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_rd_s1");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_rd_s2");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_rd_s3");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0, "w3_rd_last");
        cyc1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h5A5A_5A5A, "w3_rd_done");
        cyc1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h5A5A_5A5A, "w3_rd_hold");

        // Reset in the second stall cycle aborts the read
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h5A5A_5A5A, "w3_ab_s1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("w3_ab_s2_stall", {31'd0, stall1}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        en1 = 1'b0;
        #1;
        check("w3_ab_post_stall", {31'd0, stall1}, 32'h0);
        check("w3_ab_post_rdata", rdata1, 32'h0);
        cyc1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "w3_ab_idle");

        // Memory survives reset
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_re_s1");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_re_s2");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b1, 32'h0, "w3_re_s3");
        cyc1(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 32'h0, "w3_re_last");
        cyc1(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h5A5A_5A5A, "w3_re_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Synchronous, byte-enabled data memory on the data-SRAM side of the CPU data interface (data_sram_en/wen/addr/wdata in, data_sram_rdata out).
- Serves loads with registered read data, so the MEM stage samples rdata one cycle after EX issues the access.
- Optional read wait-states assert stallreq toward the pipeline stall controller to emulate slow memory.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 0, extra read latency in cycles. 0 = single-cycle read, no stall.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_sram_en  input  1  access request.
- data_sram_wen  input  4  byte write enables. 0 = read. wen[3] maps to bits 31:24 … wen[0] maps to bits 7:0.
- data_sram_addr  input  32  byte address. Word index = addr[ADDR_W+1:2]. addr[1:0] and upper bits are ignored.
- data_sram_wdata  input  32  store data, already lane-aligned by EX.
- data_sram_rdata  output  32  registered read data. Full word; MEM performs lane extract and extension.
- stallreq  output  1  request to hold the pipeline while a read is pending.

Behaviour:
- Request decode:
  - write = en & (wen != 0).
  - read = en & (wen == 0).
  - en = 0 is idle.
- Reset (rst = 1 at a rising edge):
  - state <= IDLE, counter <= 0, data_sram_rdata <= 0.
  - stallreq = 0 from the following cycle.
  - Array contents are not cleared.
- Writes:
  - Committed at the edge ending the request cycle, in any state except WAIT/LAST.
  - Only enabled byte lanes are updated; other lanes keep their values.
  - Writes never stall and never change data_sram_rdata.
- Reads with WAIT_CYCLES = 0:
  - Read in cycle N: data_sram_rdata <= mem[idx] at the end of N, valid throughout N+1.
  - stallreq stays 0.
  - Back-to-back reads are supported, one per cycle.
- Reads with WAIT_CYCLES = W > 0 use the FSM below.
  - IDLE:
    - A read raises stallreq combinationally in that cycle.
    - Counter <= W-1.
    - Next state = WAIT if W > 1, else LAST.
  - WAIT:
    - stallreq = 1; counter decrements each cycle.
    - Go to LAST when counter == 1 at the edge.
    - Bus inputs are ignored; the pipeline holds them stable.
  - LAST:
    - stallreq = 0.
    - data_sram_rdata <= mem[idx] from the held address.
    - Next state = IDLE.
    - The held request is NOT treated as a new access.
  - Result: exactly W stall cycles, and rdata is valid in cycle N+W+1.
- data_sram_rdata holds its last read value through idle cycles, writes and stalls.
- Read and write to the same word:
  - Different cycles: the read returns the written data.
  - The same cycle cannot occur, since wen decides between read and write.
- Reset during WAIT or LAST: abort, go to IDLE, rdata = 0. The pending read is lost.
- Address wrap: idx uses only ADDR_W bits, so addr 4*2**ADDR_W aliases word 0.
- stallreq depends on state and on en/wen only. There is no combinational path from addr or wdata.

Test Plan:
- W=0, write addr 0x10, wen=4'b1111, wdata=0xDEADBEEF; then read 0x10 → rdata=0xDEADBEEF one cycle after the read; stallreq always 0.
- W=0, word at 0x20 holds 0x11223344; write wen=4'b0100, wdata=0x00AA0000; read 0x20 → 0x11AA3344. Then wen=4'b0011, wdata=0x0000BBCC → 0x11AABBCC.
- W=0, back-to-back reads 0x0, 0x4, 0x8 holding 1, 2, 3 → rdata 1, 2, 3 on consecutive cycles; rdata stays 3 through 2 idle cycles and an intervening write.
- W=3, read 0x40 (holds 0x5A5A5A5A) held stable → stallreq high exactly 3 cycles, then low; rdata=0x5A5A5A5A in the cycle after stallreq falls; no second access is launched.
- W=3, assert rst in the second stall cycle → stallreq=0 and rdata=0 next cycle, state IDLE. A subsequent read of 0x40 still returns 0x5A5A5A5A (memory preserved).
- ADDR_W=10, write 0x77 to addr 0x1000 → read addr 0x0 returns 0x77 (wrap); read addr 0x1003 also returns 0x77 (low bits ignored).
